// File: rtl/audio_adsr_vca.sv
// ---------------------------------------------------------------------------
// audio_adsr_vca
// ADSR envelope generator driving a VCA. Sits after the oscillator stage and
// shapes its raw sample with the current envelope. All state advances only on
// the one-cycle sample strobe, so envelope timing does not depend on clk.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   tick           sample strobe, high for one clk per sample period
//   gate           note on/off, sampled only on tick
//   attack_step    attack rate (0 = instant)
//   decay_step     decay rate (0 = instant)
//   sustain_level  sustain level, target = {sustain_level, sustain_level}
//   release_step   release rate (0 = instant)
//   sample_in      signed oscillator sample
//   sample_out     signed shaped sample (one tick behind the envelope)
//   env_level      unsigned current envelope value
//   state          IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   busy           high whenever state != IDLE
// ---------------------------------------------------------------------------
module audio_adsr_vca #(
    parameter int unsigned STEP_SHIFT_A  = 8,
    parameter int unsigned STEP_SHIFT_DR = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        gate,
    input  logic [7:0]  attack_step,
    input  logic [7:0]  decay_step,
    input  logic [7:0]  sustain_level,
    input  logic [7:0]  release_step,
    input  logic [15:0] sample_in,
    output logic [15:0] sample_out,
    output logic [15:0] env_level,
    output logic [2:0]  state,
    output logic        busy
);

    localparam int unsigned ENV_W = 16;
    localparam int unsigned SUM_W = ENV_W + 1;
    localparam int unsigned PRD_W = 2 * ENV_W + 1;

    localparam logic [SUM_W-1:0] ENV_MAX_EXT = 17'h0FFFF;
    localparam logic [SUM_W-1:0] INST_INC    = 17'h10000;
    localparam logic [ENV_W-1:0] ENV_MAX     = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ATTACK  = 3'd1,
        S_DECAY   = 3'd2,
        S_SUSTAIN = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t           r_state;
    logic [ENV_W-1:0] r_env;
    logic [ENV_W-1:0] r_sample;
    logic             r_busy;

    // Attack: 17-bit sum so a full-scale step is visible as overflow
    logic [SUM_W-1:0] w_attack_inc;
    logic [SUM_W-1:0] w_attack_sum;
    logic             w_attack_done;

    assign w_attack_inc  = (attack_step == 8'd0) ? INST_INC
                                                 : (SUM_W'(attack_step) << STEP_SHIFT_A);
    assign w_attack_sum  = {1'b0, r_env} + w_attack_inc;
    assign w_attack_done = (w_attack_sum >= ENV_MAX_EXT);

    // Decay: signed difference so overshooting below the target clamps to it
    logic [ENV_W-1:0]        w_target;
    logic signed [SUM_W-1:0] w_decay_dec;
    logic signed [SUM_W-1:0] w_decay_diff;
    logic                    w_decay_done;

    assign w_target     = {sustain_level, sustain_level};
    assign w_decay_dec  = $signed(SUM_W'(decay_step) << STEP_SHIFT_DR);
    assign w_decay_diff = $signed({1'b0, r_env}) - w_decay_dec;
    assign w_decay_done = (decay_step == 8'd0)
                       || (w_decay_diff <= $signed({1'b0, w_target}));

    // Release: stop at zero instead of wrapping
    logic [SUM_W-1:0] w_release_dec;
    logic [ENV_W-1:0] w_release_diff;
    logic             w_release_done;

    assign w_release_dec  = SUM_W'(release_step) << STEP_SHIFT_DR;
    assign w_release_diff = ENV_W'({1'b0, r_env} - w_release_dec);
    assign w_release_done = (release_step == 8'd0) || ({1'b0, r_env} <= w_release_dec);

    // VCA: signed sample times zero-extended envelope, keep bits [31:16]
    logic signed [PRD_W-1:0] w_prod;
    logic [ENV_W-1:0]        w_vca;

    assign w_prod = $signed({{(ENV_W+1){sample_in[ENV_W-1]}}, sample_in})
                  * $signed({{(ENV_W+1){1'b0}}, r_env});
    assign w_vca  = ENV_W'(w_prod >>> ENV_W);

    // Gate edges take priority over the per-state step
    logic w_gate_off;
    logic w_gate_on;

    assign w_gate_off = !gate && ((r_state == S_ATTACK) || (r_state == S_DECAY)
                                  || (r_state == S_SUSTAIN));
    assign w_gate_on  = gate && ((r_state == S_IDLE) || (r_state == S_RELEASE));

    // Envelope FSM and VCA output register, advancing only on tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_env    <= '0;
            r_sample <= '0;
            r_busy   <= 1'b0;
        end else if (tick) begin
            // Uses the envelope value from before this tick's update
            r_sample <= w_vca;

            if (w_gate_off) begin
                r_state <= S_RELEASE;
                r_busy  <= 1'b1;
            end else if (w_gate_on) begin
                // Retrigger continues from the current level
                r_state <= S_ATTACK;
                r_busy  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_env  <= '0;
                        r_busy <= 1'b0;
                    end
                    S_ATTACK: begin
                        if (w_attack_done) begin
                            r_env   <= ENV_MAX;
                            r_state <= S_DECAY;
                        end else begin
                            r_env <= ENV_W'(w_attack_sum);
                        end
                    end
                    S_DECAY: begin
                        if (w_decay_done) begin
                            r_env   <= w_target;
                            r_state <= S_SUSTAIN;
                        end else begin
                            r_env <= ENV_W'(w_decay_diff);
                        end
                    end
                    S_SUSTAIN: begin
                        // Track live sustain changes
                        r_env <= w_target;
                    end
                    S_RELEASE: begin
                        if (w_release_done) begin
                            r_env   <= '0;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_env <= w_release_diff;
                        end
                    end
                    default: begin
                        r_env   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sample_out = r_sample;
    assign env_level  = r_env;
    assign state      = r_state;
    assign busy       = r_busy;

endmodule
